burst_mem_responder: RTL and testbench
======================================

Name: burst_mem_responder

Overview:
- Synthesizable physical-memory responder: the far end of the 64-bit burst interface driven by cacheline_adaptor.
- Serves 256-bit line reads and writes as four 64-bit beats after a programmable access latency, from an internal line-addressed array.
- Stands in for pmem in the cache-subsystem bench and in FPGA bring-up, so the L1/L2/EWB hierarchy can be exercised with realistic, controllable latency.

Parameters:
- LINES_LOG2, 8, log2 of number of 32-byte lines stored (default 256 lines = 8 KiB).
- LATENCY, 4, wait cycles between request capture and first beat; range 0..255.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- read_i  in  1  line read request from the adaptor
- write_i  in  1  line write request from the adaptor
- address_i  in  32  byte address; bits [4:0] ignored
- burst_i  in  64  write beat data from the adaptor
- burst_o  out  64  read beat data to the adaptor
- resp_o  out  1  beat valid/accepted strobe, high for exactly 4 consecutive cycles per request
- err_o  out  1  one-cycle pulse on an illegal request (read_i and write_i both high)

Behaviour:
- Reset (async assert, sync release): state IDLE, resp_o=0, burst_o=0, err_o=0, counters=0. Array contents are not reset and are undefined until written.
- Reset mid-operation: the burst is abandoned immediately. Any beats already written stay in the array; remaining beats are not written.
- Line index = address_i[LINES_LOG2+4:5]. Upper address bits are ignored, so addresses alias modulo 2^(LINES_LOG2+5).
- Word address for a beat = {line, beat[1:0]}; beat 0 holds line bits [63:0], and so on up to beat 3.
- IDLE:
  - exactly one of read_i/write_i high at edge E0 → capture op and line into registers.
  - Go to WAIT if LATENCY>0, else BURST.
  - Both high → remain IDLE and assert err_o for the next cycle.
- WAIT: counter counts LATENCY cycles, then → BURST. Inputs are not monitored; a dropped request still completes.
- BURST:
  - resp_o high in cycles E0+LATENCY+1 through E0+LATENCY+4; beat counter 0..3.
  - Read: burst_o is registered and carries beat k in the same cycle resp_o is high for beat k.
  - Write: burst_i is sampled and stored on the rising edge that ends the cycle in which resp_o is high for beat k. The initiator presents beat 0 with the request and advances one beat per resp_o cycle.
  - After beat 3 → DONE.
- DONE:
  - One cycle with resp_o=0; then → IDLE.
  - The initiator must deassert its request by this edge; a request still high in IDLE starts a new transaction.
- burst_o = 0 whenever resp_o = 0.
- Captured address and op are held for the whole transaction; changes on address_i after E0 are ignored.
- Minimum back-to-back turnaround: LATENCY+6 cycles per line.
- The array is single-port; one access per cycle is sufficient.

Decomposition:
- Package burst_mem_pkg holds:
  - BEATS=4, BEAT_W=64, LINE_BYTES=32, OFFSET_BITS=5;
  - state enum {IDLE, WAIT, BURST, DONE};
  - op enum {OP_RD, OP_WR}.
- Sub-module resp_mem_array: single-port, synchronous-read 64-bit array of depth 4·2^LINES_LOG2, with a write-enable port.
- The FSM, latency/beat counters and output registers live in burst_mem_responder.

Test Plan:
- Write-then-read, LATENCY=4: write line 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, then read the same line → resp_o high cycles E0+5..E0+8 and burst_o returns the 4 beats in order.
- LATENCY=0: read request at E0 → resp_o high E0+1..E0+4, low at E0+5 (DONE), accepted again in IDLE at E0+6.
- Aliasing and offset: write line 0x0000_2000 (LINES_LOG2=8), read 0x0000_001F and 0x0000_0000 → both return the data of line 0.
- Illegal request: read_i=write_i=1 for one cycle → err_o pulses once, resp_o stays 0, state stays IDLE, array unchanged.
- Dropped request: read_i deasserted during WAIT → still exactly 4 resp_o beats, then IDLE.
- Reset mid-write: reset_n low after beat 1 → resp_o=0 immediately. A subsequent read of the line returns new beats 0–1; beats 2–3 keep their prior values.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// Shared constants and enumerations for the burst memory responder.
package burst_mem_pkg;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/resp_mem_array.sv
// Single-port 64-bit storage with synchronous read; contents are never reset.
module resp_mem_array
    import burst_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BEAT_W-1:0] wdata_i,
    output logic [BEAT_W-1:0] rdata_o
);

    logic [BEAT_W-1:0] mem_q [2**ADDR_W];
    logic [BEAT_W-1:0] rdata_q;

    // Write on enable, read-before-write registered output every cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Far-end line memory for the 64-bit burst interface: serves 4-beat line
// reads/writes after a fixed access latency.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LINES_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] address_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        err_o
);

    localparam int          WORD_W    = LINES_LOG2 + 2;
    localparam logic [7:0]  LAT_LAST  = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;
    localparam logic [1:0]  BEAT_LAST = 2'(BEATS - 1);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [LINES_LOG2-1:0]   line_q, line_d;
    logic [7:0]              lat_q, lat_d;
    logic [1:0]              beat_q, beat_d;
    logic [1:0]              out_beat_q, out_beat_d;
    logic                    resp_q, resp_d;
    logic [BEAT_W-1:0]       burst_q, burst_d;
    logic                    err_q, err_d;

    logic                    mem_we_s;
    logic [WORD_W-1:0]       mem_addr_s;
    logic [BEAT_W-1:0]       mem_rdata_s;
    logic                    unused_addr_s;

    assign unused_addr_s = ^{address_i[31:LINES_LOG2+OFFSET_BITS], address_i[OFFSET_BITS-1:0]};

    // Writes land on the beat currently being acknowledged; reads fetch one
    // cycle ahead so the registered burst_o lines up with resp_o.
    assign mem_we_s   = resp_q && (op_q == OP_WR);
    assign mem_addr_s = mem_we_s ? {line_q, out_beat_q} : {line_d, beat_d};

    resp_mem_array #(
        .ADDR_W (WORD_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we_s),
        .addr_i  (mem_addr_s),
        .wdata_i (burst_i),
        .rdata_o (mem_rdata_s)
    );

    // Next-state and output computation for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        line_d     = line_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        out_beat_d = beat_q;
        resp_d     = 1'b0;
        burst_d    = '0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_i && write_i) begin
                    err_d = 1'b1;
                end else if (read_i || write_i) begin
                    op_d    = write_i ? OP_WR : OP_RD;
                    line_d  = address_i[LINES_LOG2+OFFSET_BITS-1:OFFSET_BITS];
                    lat_d   = 8'd0;
                    beat_d  = 2'd0;
                    state_d = (LATENCY > 0) ? WAIT : BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = BURST;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            BURST: begin
                resp_d  = 1'b1;
                burst_d = (op_q == OP_RD) ? mem_rdata_s : '0;
                if (beat_q == BEAT_LAST) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= OP_RD;
            line_q     <= '0;
            lat_q      <= 8'd0;
            beat_q     <= 2'd0;
            out_beat_q <= 2'd0;
            resp_q     <= 1'b0;
            burst_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            line_q     <= line_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            out_beat_q <= out_beat_d;
            resp_q     <= resp_d;
            burst_q    <= burst_d;
            err_q      <= err_d;
        end
    end

    assign burst_o = burst_q;
    assign resp_o  = resp_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized scoreboard bench: one responder with LATENCY=4, one with LATENCY=0.
module tb_burst_mem_responder;

    localparam int LL    = 8;
    localparam int LAT_A = 4;

    typedef struct packed {
        logic        chk;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [63:0] bin  [2];
    logic [63:0] bout [2];
    logic        resp [2];
    logic        err  [2];

    int checks = 0;
    int errors = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    logic [255:0] ref_line [2][256];
    bit           ref_vld  [2][256];

    always #5 clk = ~clk;

    burst_mem_responder #(.LINES_LOG2(LL), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .read_i(rd[0]), .write_i(wr[0]),
        .address_i(addr[0]), .burst_i(bin[0]), .burst_o(bout[0]),
        .resp_o(resp[0]), .err_o(err[0])
    );

    burst_mem_responder #(.LINES_LOG2(LL), .LATENCY(0)) dut_z (
        .clk(clk), .reset_n(reset_n), .read_i(rd[1]), .write_i(wr[1]),
        .address_i(addr[1]), .burst_i(bin[1]), .burst_o(bout[1]),
        .resp_o(resp[1]), .err_o(err[1])
    );

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void sb_push(input int i, input exp_t e);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    function automatic int sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t sb_pop(input int i);
        return (i == 0) ? sb0.pop_front() : sb1.pop_front();
    endfunction

    // Monitor: every acknowledged beat consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (resp[i]) begin
                    if (sb_size(i) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp inst%0d: got resp=1 expected 0", i);
                    end else begin
                        e = sb_pop(i);
                        if (e.chk) check_eq("read_beat", bout[i], e.data);
                    end
                end else begin
                    check_eq("burst_zero_when_idle", bout[i], 64'd0);
                end
            end
        end
    end

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % 256);
    endfunction

    task automatic do_txn(input int i, input bit is_wr, input logic [31:0] a,
                          input logic [255:0] d, input int drop_c);
        int   lat, c, seen, first, ln;
        exp_t e;
        lat = (i == 0) ? LAT_A : 0;
        ln  = line_of(a);
        for (int k = 0; k < 4; k++) begin
            e.chk  = !is_wr && ref_vld[i][ln];
            e.data = ref_line[i][ln][64*k +: 64];
            sb_push(i, e);
        end
        if (is_wr) begin
            ref_line[i][ln] = d;
            ref_vld[i][ln]  = 1'b1;
        end
        @(negedge clk);
        rd[i] = !is_wr; wr[i] = is_wr; addr[i] = a; bin[i] = d[63:0];
        @(posedge clk);
        c = 0; seen = 0; first = -1;
        while (seen < 4 && c < LAT_A + 50) begin
            @(negedge clk);
            bin[i]  = d[64*seen +: 64];
            addr[i] = $urandom;
            if (resp[i]) begin
                if (first < 0) first = c;
                seen++;
            end
            if (c >= drop_c || seen == 4) begin
                rd[i] = 1'b0; wr[i] = 1'b0;
            end
            c++;
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
        check_eq("first_beat_cycle", 64'(first), 64'(lat + 1));
        check_eq("last_beat_cycle", 64'(c - 1), 64'(lat + 4));
        check_eq("beat_count", 64'(seen), 64'd4);
    endtask

    task automatic illegal_req(input int i, input logic [31:0] a);
        @(negedge clk);
        rd[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; bin[i] = {$urandom, $urandom};
        @(negedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
        check_eq("err_pulse", 64'(err[i]), 64'd1);
        check_eq("err_no_resp", 64'(resp[i]), 64'd0);
        @(negedge clk);
        check_eq("err_one_cycle", 64'(err[i]), 64'd0);
        repeat (LAT_A + 6) @(negedge clk);
    endtask

    task automatic reset_mid_write(input logic [31:0] a, input logic [255:0] d);
        int           c, seen, ln;
        logic [255:0] old;
        exp_t         e;
        ln  = line_of(a);
        old = ref_line[0][ln];
        e.chk = 1'b0; e.data = 64'd0;
        for (int k = 0; k < 4; k++) sb_push(0, e);
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = a; bin[0] = d[63:0];
        @(posedge clk);
        c = 0; seen = 0;
        while (seen < 2 && c < LAT_A + 50) begin
            @(negedge clk);
            bin[0] = d[64*seen +: 64];
            if (resp[0]) seen++;
            c++;
        end
        check_eq("rst_write_beats_seen", 64'(seen), 64'd2);
        @(negedge clk);
        bin[0] = d[64*seen +: 64];
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_resp_drop", 64'(resp[0]), 64'd0);
        check_eq("rst_burst_zero", bout[0], 64'd0);
        sb0.delete();
        wr[0] = 1'b0;
        ref_line[0][ln] = {old[255:128], d[127:0]};
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] pat;
        logic [31:0]  a;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; bin[i] = 64'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_resp", 64'(resp[i]), 64'd0);
            check_eq("reset_burst", bout[i], 64'd0);
            check_eq("reset_err", 64'(err[i]), 64'd0);
        end
        reset_n = 1'b1;

        pat = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        for (int i = 0; i < 2; i++) begin
            do_txn(i, 1'b1, 32'h0000_0040, pat, 99);
            do_txn(i, 1'b0, 32'h0000_0040, 256'd0, 99);
            do_txn(i, 1'b0, 32'h0000_0040, 256'd0, 99);
            do_txn(i, 1'b1, 32'h0000_2000, rand_line(), 99);
            do_txn(i, 1'b0, 32'h0000_001F, 256'd0, 99);
            do_txn(i, 1'b0, 32'h0000_0000, 256'd0, 99);
        end

        illegal_req(0, 32'h0000_0040);
        do_txn(0, 1'b0, 32'h0000_0040, 256'd0, 99);
        illegal_req(1, 32'h0000_0040);
        do_txn(1, 1'b0, 32'h0000_0040, 256'd0, 99);

        do_txn(0, 1'b0, 32'h0000_0040, 256'd0, 1);
        do_txn(0, 1'b0, 32'h0000_0040, 256'd0, 0);

        for (int n = 0; n < 80; n++) begin
            a = ($urandom & 32'hFFFF_E01F) | (32'($urandom_range(0, 7)) << 5);
            do_txn(n % 2, 1'($urandom_range(0, 1)), a, rand_line(),
                   (n % 2 == 0) ? int'($urandom_range(0, 8)) : 99);
        end

        do_txn(0, 1'b1, 32'h0000_0080, rand_line(), 99);
        reset_mid_write(32'h0000_0080, rand_line());
        do_txn(0, 1'b0, 32'h0000_0080, 256'd0, 99);
        do_txn(1, 1'b0, 32'h0000_0040, 256'd0, 99);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty_a", 64'(sb0.size()), 64'd0);
        check_eq("scoreboard_empty_z", 64'(sb1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
